reg_file_access_ctrl: RTL
=========================

// Module: reg_file_access_ctrl
// PURPOSE
//  Initiator for REGISTER_FILE_32x32: accepts single-beat requests on a valid/ready
//  port, drives the file's READ/WRITE strobes, addresses and write data with the
//  file's timing, then returns a response on a valid/ready port. Sits between the
//  control unit and the register file. Provides read-pair, write and bulk fill.
// PARAMETERS
//  DATA_WIDTH  32  register width
//  ADDR_WIDTH  5   register address width
//  NUM_REGS    32  registers swept by FILL (<= 2**ADDR_WIDTH)
// PORTS
//  CLK          in   1   clock, all state changes on posedge
//  RST          in   1   async active-low reset
//  REQ_VALID    in   1   request present
//  REQ_READY    out  1   request accepted on posedge when VALID&READY
//  REQ_OP       in   2   00 READ pair, 01 WRITE, 10 FILL, 11 reserved
//  REQ_ADDR_A   in   5   read addr 1 / write addr
//  REQ_ADDR_B   in   5   read addr 2
//  REQ_WDATA    in   32  write / fill data
//  RESP_VALID   out  1   response present, held until RESP_READY
//  RESP_READY   in   1   response consumed on posedge when VALID&READY
//  RESP_DATA_A  out  32  read data from ADDR_A (0 for WRITE/FILL/reserved)
//  RESP_DATA_B  out  32  read data from ADDR_B (0 for WRITE/FILL/reserved)
//  RESP_ERR     out  1   1 only for reserved op
//  BUSY         out  1   state != IDLE
//  RF_READ      out  1   to file READ
//  RF_WRITE     out  1   to file WRITE
//  RF_ADDR_R1   out  5   to file ADDR_R1
//  RF_ADDR_R2   out  5   to file ADDR_R2
//  RF_ADDR_W    out  5   to file ADDR_W
//  RF_DATA_W    out  32  to file DATA_W
//  RF_DATA_R1   in   32  from file DATA_R1
//  RF_DATA_R2   in   32  from file DATA_R2
// BEHAVIOUR
//  - States: IDLE, RD, CAP, WR, FILL, RESP. REQ_READY = (state==IDLE); BUSY = !REQ_READY.
//  - Reset (RST=0, async): state IDLE; RF_READ=RF_WRITE=0; all RF addr/data, RESP_*,
//    fill counter = 0. Mid-operation reset aborts at once; pending response dropped.
//  - Accept (edge E0): latch op/addrs/data. READ->RD, WRITE->WR, FILL->FILL (cnt=0),
//    reserved->RESP with ERR=1, data 0.
//  - RD (E0..E1): RF_READ=1, RF_ADDR_R1=A, RF_ADDR_R2=B. E1 -> CAP.
//  - CAP (E1..E2): RF_READ stays 1; at E2 RESP_DATA_A/B <= RF_DATA_R1/R2 -> RESP.
//    READ latency: RESP_VALID high 2 cycles after accept.
//  - WR (E0..E1): RF_WRITE=1, RF_ADDR_W=A, RF_DATA_W=WDATA; E1 -> RESP, data 0.
//  - FILL: one write per cycle, RF_ADDR_W=cnt, RF_DATA_W=WDATA, cnt+1 each edge;
//    at edge where cnt==NUM_REGS-1 -> RESP. Exactly NUM_REGS write cycles; cnt
//    never wraps; RESP_VALID NUM_REGS cycles after accept.
//  - RF_READ and RF_WRITE never 1 together (file treats 1/1 as hold). Both 0 in
//    IDLE and RESP. RF addresses/data hold last driven value outside active states.
//  - RESP: RESP_VALID=1, DATA/ERR stable until RESP_READY=1 at posedge -> IDLE,
//    RESP_VALID=0. Backpressure indefinite. No new accept before IDLE, so
//    back-to-back requests have >=1 IDLE cycle; REQ inputs ignored while BUSY.
//  - RESP_ERR cleared on every accept; set only for op 11.
// TESTING
//  1 RST low 10ns mid-FILL (cnt=7) -> strobes 0 instantly, BUSY=0, RESP_VALID=0,
//    next FILL restarts at addr 0.
//  2 WRITE A=5 WDATA=0xA5A5_0005 then READ A=5 B=0 -> RF_WRITE 1 cycle only,
//    RESP_DATA_A=0xA5A5_0005, RESP_DATA_B=file reg0, RESP_VALID 2 cycles after accept.
//  3 FILL WDATA=0x1234_5678 -> 32 consecutive RF_WRITE cycles addr 0..31, then
//    READ every addr i,i -> all 0x1234_5678; RF_READ&RF_WRITE never both 1.
//  4 WRITE i to addr i for i=0..31, READ pairs (i,31-i) -> DATA_A=i, DATA_B=31-i.
//  5 READ with RESP_READY low 20 cycles -> RESP_VALID/DATA stable, REQ_READY=0,
//    second REQ_VALID ignored until consume.
//  6 REQ_OP=11 -> RESP 1 cycle after accept, ERR=1, data 0, no RF strobe; next WRITE ERR=0.

Source files
------------

// File: rtl/reg_file_access_ctrl.sv
// Request/response initiator for a 32x32 register file: read-pair, single write
// and bulk fill, driving the file's READ/WRITE strobes with its two-cycle read timing.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | ready for a request, both file strobes low
//  RD     | READ asserted, read addresses presented to the file
//  CAP    | READ still asserted, file data captured at the closing edge
//  WR     | single WRITE cycle
//  FILL   | one WRITE per cycle, address = fill counter
//  RESP   | response held until consumed
module reg_file_access_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr_a,
   input  logic [ADDR_WIDTH-1:0] req_addr_b,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data_a,
   output logic [DATA_WIDTH-1:0] resp_data_b,
   output logic                  resp_err,
   output logic                  busy,
   output logic                  rf_read,
   output logic                  rf_write,
   output logic [ADDR_WIDTH-1:0] rf_addr_r1,
   output logic [ADDR_WIDTH-1:0] rf_addr_r2,
   output logic [ADDR_WIDTH-1:0] rf_addr_w,
   output logic [DATA_WIDTH-1:0] rf_data_w,
   input  logic [DATA_WIDTH-1:0] rf_data_r1,
   input  logic [DATA_WIDTH-1:0] rf_data_r2
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_CAP  = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_FILL = 3'd4;
   localparam logic [2:0] S_RESP = 3'd5;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b10;

   localparam logic [ADDR_WIDTH-1:0] FILL_LAST = ADDR_WIDTH'(NUM_REGS - 1);

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] fill_cnt;

   assign req_ready = (state == S_IDLE);
   assign busy      = ~req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         fill_cnt    <= '0;
         rf_read     <= 1'b0;
         rf_write    <= 1'b0;
         rf_addr_r1  <= '0;
         rf_addr_r2  <= '0;
         rf_addr_w   <= '0;
         rf_data_w   <= '0;
         resp_valid  <= 1'b0;
         resp_data_a <= '0;
         resp_data_b <= '0;
         resp_err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  resp_data_a <= '0;
                  resp_data_b <= '0;
                  resp_err    <= 1'b0;
                  case (req_op)
                     OP_READ: begin
                        rf_read    <= 1'b1;
                        rf_addr_r1 <= req_addr_a;
                        rf_addr_r2 <= req_addr_b;
                        state      <= S_RD;
                     end
                     OP_WRITE: begin
                        rf_write  <= 1'b1;
                        rf_addr_w <= req_addr_a;
                        rf_data_w <= req_wdata;
                        state     <= S_WR;
                     end
                     OP_FILL: begin
                        rf_write  <= 1'b1;
                        rf_addr_w <= '0;
                        rf_data_w <= req_wdata;
                        fill_cnt  <= '0;
                        state     <= S_FILL;
                     end
                     default: begin
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                     end
                  endcase
               end
            end
            S_RD: begin
               state <= S_CAP;
            end
            S_CAP: begin
               resp_data_a <= rf_data_r1;
               resp_data_b <= rf_data_r2;
               rf_read     <= 1'b0;
               resp_valid  <= 1'b1;
               state       <= S_RESP;
            end
            S_WR: begin
               rf_write   <= 1'b0;
               resp_valid <= 1'b1;
               state      <= S_RESP;
            end
            S_FILL: begin
               // stop on the last address so the counter never wraps
               if (fill_cnt == FILL_LAST) begin
                  rf_write   <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= S_RESP;
               end else begin
                  fill_cnt  <= fill_cnt + 1'b1;
                  rf_addr_w <= fill_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: begin
               rf_read    <= 1'b0;
               rf_write   <= 1'b0;
               resp_valid <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule
